icache_refill_ctrl: RTL and testbench



---
 rtl/fetch_mem_pkg.sv | 29 ++
 rtl/icache_refill_ctrl_if.sv | 45 ++++
 rtl/refill_block_assembler.sv | 49 ++++
 rtl/icache_refill_ctrl.sv | 101 ++++++++++
 tb/tb_icache_refill_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fetch_mem_pkg
//  Description : Shared widths and refill-state encoding for the L1-I miss
//                refill path (fetch stage <-> L2/memory port).
//  Contents    : SIZE_PC, CACHE_WIDTH, BEAT_WIDTH, BEATS, BEAT_CNT_W,
//                OFFSET_W, REFILL_CNT_W, refill_state_e
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_mem_pkg;

    localparam int SIZE_PC      = 32;
    localparam int CACHE_WIDTH  = 256;
    localparam int BEAT_WIDTH   = 64;
    localparam int BEATS        = CACHE_WIDTH / BEAT_WIDTH;
    localparam int BEAT_CNT_W   = $clog2(BEATS);
    // Byte-offset bits dropped when aligning an address to a cache block.
    localparam int OFFSET_W     = $clog2(CACHE_WIDTH / 8);
    localparam int REFILL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RESP  = 2'd2,
        ST_WRITE = 2'd3
    } refill_state_e;

endpackage
`default_nettype wire

// File: rtl/icache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : icache_refill_ctrl_if
//  Description : Bundles the fetch-stage miss/fill signals and the memory
//                request/response signals of the instruction-cache refill
//                controller.
//  Modports    : master - fetch stage + memory model side (drives *_i)
//                slave  - refill controller side (drives *_o)
//  Revision    : 1.0 - initial release
// ============================================================================
interface icache_refill_ctrl_if;
    import fetch_mem_pkg::*;

    // fetch stage -> controller
    logic                     miss_i;
    logic [SIZE_PC-1:0]       missAddr_i;
    // controller -> memory
    logic                     memReqValid_o;
    logic [SIZE_PC-1:0]       memReqAddr_o;
    // memory -> controller
    logic                     memReqReady_i;
    logic                     memRespValid_i;
    logic [BEAT_WIDTH-1:0]    memRespData_i;
    // controller -> fetch stage
    logic                     wrEnable_o;
    logic [SIZE_PC-1:0]       wrAddr_o;
    logic [CACHE_WIDTH-1:0]   instBlock_o;
    // status
    logic                     busy_o;
    logic [REFILL_CNT_W-1:0]  refillCount_o;

    modport master (
        output miss_i, missAddr_i, memReqReady_i, memRespValid_i, memRespData_i,
        input  memReqValid_o, memReqAddr_o, wrEnable_o, wrAddr_o, instBlock_o,
               busy_o, refillCount_o
    );

    modport slave (
        input  miss_i, missAddr_i, memReqReady_i, memRespValid_i, memRespData_i,
        output memReqValid_o, memReqAddr_o, wrEnable_o, wrAddr_o, instBlock_o,
               busy_o, refillCount_o
    );

endinterface
`default_nettype wire

// File: rtl/refill_block_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : refill_block_assembler
//  Description : Collects BEATS response beats into one CACHE_WIDTH block.
//                Beat n lands at bits [n*BEAT_WIDTH +: BEAT_WIDTH], so beat 0
//                (lowest address) occupies the LSBs.
//  Ports       : clk, reset   - clock, asynchronous active-high reset
//                clear        - restart the beat counter at beat 0
//                beatValid    - capture beatData this cycle
//                beatData     - one response beat
//                block        - assembled block (holds between refills)
//                lastBeat     - the beat being captured is the final one
//  Revision    : 1.0 - initial release
// ============================================================================
module refill_block_assembler
    import fetch_mem_pkg::*;
(
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   clear,
    input  wire logic                   beatValid,
    input  wire logic [BEAT_WIDTH-1:0]  beatData,
    output logic      [CACHE_WIDTH-1:0] block,
    output logic                        lastBeat
);

    logic [BEAT_CNT_W-1:0]  r_beat_cnt;
    logic [CACHE_WIDTH-1:0] r_block;

    // Combinational so the FSM can leave RESP on the same edge that
    // captures the final beat.
    assign lastBeat = beatValid && (r_beat_cnt == BEAT_CNT_W'(BEATS - 1));
    assign block    = r_block;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat_cnt <= '0;
            r_block    <= '0;
        end else if (clear) begin
            r_beat_cnt <= '0;
        end else if (beatValid) begin
            r_block[r_beat_cnt * BEAT_WIDTH +: BEAT_WIDTH] <= beatData;
            // Wraps back to 0 after the last beat.
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_ctrl
//  Description : L1 instruction-cache refill responder. Latches a fetch miss,
//                issues one block request to memory, assembles the returned
//                beats and writes the block back to the fetch stage with a
//                one-cycle fill strobe. One refill in flight at a time.
//  Ports       : clk    - clock
//                reset  - asynchronous active-high reset (aborts a refill)
//                bus    - icache_refill_ctrl_if.slave: miss_i/missAddr_i,
//                         memReq*, memResp*, wrEnable_o/wrAddr_o/instBlock_o,
//                         busy_o, refillCount_o
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
    import fetch_mem_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            reset,
    icache_refill_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_REQ   = ST_REQ;
    localparam logic [1:0] S_RESP  = ST_RESP;
    localparam logic [1:0] S_WRITE = ST_WRITE;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [SIZE_PC-1:0]      r_block_addr;
    logic                    r_req_valid;
    logic                    r_wr_en;
    logic                    r_busy;
    logic [REFILL_CNT_W-1:0] r_refill_cnt;

    logic                    w_accept;
    logic                    w_beat_valid;
    logic                    w_last_beat;
    logic [CACHE_WIDTH-1:0]  w_block;

    assign w_accept     = (r_state == S_REQ)  && bus.memReqReady_i;
    // Beats arriving in any other state (stray or post-abort) are dropped.
    assign w_beat_valid = (r_state == S_RESP) && bus.memRespValid_i;

    refill_block_assembler u_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_accept),
        .beatValid (w_beat_valid),
        .beatData  (bus.memRespData_i),
        .block     (w_block),
        .lastBeat  (w_last_beat)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.miss_i)  w_state_nxt = S_REQ;
            S_REQ:   if (w_accept)    w_state_nxt = S_RESP;
            S_RESP:  if (w_last_beat) w_state_nxt = S_WRITE;
            S_WRITE:                  w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // Status/strobe outputs are decoded from the next state so they are
    // true registers aligned with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_block_addr <= '0;
            r_req_valid  <= 1'b0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_refill_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_valid <= (w_state_nxt == S_REQ);
            r_wr_en     <= (w_state_nxt == S_WRITE);
            r_busy      <= (w_state_nxt != S_IDLE);
            // Miss address is only captured in IDLE; redirects during a
            // refill do not disturb the block in flight.
            if ((r_state == S_IDLE) && bus.miss_i) begin
                r_block_addr <= {bus.missAddr_i[SIZE_PC-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
            if (r_state == S_WRITE) begin
                r_refill_cnt <= r_refill_cnt + 1'b1;
            end
        end
    end

    assign bus.memReqValid_o = r_req_valid;
    assign bus.memReqAddr_o  = r_block_addr;
    assign bus.wrEnable_o    = r_wr_en;
    assign bus.wrAddr_o      = r_block_addr;
    assign bus.instBlock_o   = w_block;
    assign bus.busy_o        = r_busy;
    assign bus.refillCount_o = r_refill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_refill_ctrl
//  Description : Self-checking bench for icache_refill_ctrl. Table-driven
//                refills plus hand-written corner sequences; every fill is
//                checked against a scoreboard of expected {addr, block}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;
    import fetch_mem_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    icache_refill_ctrl_if bus();

    icache_refill_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_cnt = 16'd0;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] blk;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] miss_addr;
        int          rdly;
        int          gap;
        bit          stray;
        logic [63:0] seed;
        logic [31:0] exp_addr;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_val(input logic [63:0] seed, input int i);
        return seed * 64'(i + 1);
    endfunction

    function automatic logic [255:0] make_block(input logic [63:0] seed);
        logic [255:0] b;
        b = {beat_val(seed, 3), beat_val(seed, 2), beat_val(seed, 1), beat_val(seed, 0)};
        return b;
    endfunction

    // Scoreboard: each fill strobe must match the oldest pending refill.
    always @(negedge clk) begin
        exp_t e;
        if (bus.wrEnable_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got wrEnable_o=1 addr=%0h required no fill", bus.wrAddr_o);
            end else begin
                e = sb.pop_front();
                chk("sb_wr_addr", 256'(bus.wrAddr_o), 256'(e.addr));
                chk("sb_block", bus.instBlock_o, e.blk);
            end
        end
    end

    task automatic send_beats(input logic [63:0] seed, input int gap, output int steps);
        steps = 0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.memRespValid_i = 1'b0;
                step();
                steps++;
            end
            bus.memRespValid_i = 1'b1;
            bus.memRespData_i  = beat_val(seed, i);
            step();
            steps++;
        end
        bus.memRespValid_i = 1'b0;
        bus.memRespData_i  = '0;
    endtask

    task automatic run_refill(input vec_t v);
        int n;
        int s;
        if (v.stray) begin
            bus.memRespValid_i = 1'b1;
            bus.memRespData_i  = 64'hDEAD_BEEF_DEAD_BEEF;
            step();
            bus.memRespValid_i = 1'b0;
        end
        sb.push_back('{v.exp_addr, make_block(v.seed)});
        bus.miss_i     = 1'b1;
        bus.missAddr_i = v.miss_addr;
        step();
        n = 1;
        bus.miss_i = 1'b0;
        for (int k = 0; k <= v.rdly; k++) begin
            chk("req_valid", 256'(bus.memReqValid_o), 256'(1));
            chk("req_addr", 256'(bus.memReqAddr_o), 256'(v.exp_addr));
            chk("busy_req", 256'(bus.busy_o), 256'(1));
            bus.memReqReady_i = (k == v.rdly);
            step();
            n++;
        end
        bus.memReqReady_i = 1'b0;
        chk("req_single_handshake", 256'(bus.memReqValid_o), 256'(0));
        send_beats(v.seed, v.gap, s);
        n += s;
        while (bus.wrEnable_o !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk("wr_latency", 256'(n), 256'(6 + v.rdly + 4 * v.gap));
        step();
        exp_cnt++;
        chk("wr_one_cycle", 256'(bus.wrEnable_o), 256'(0));
        chk("busy_done", 256'(bus.busy_o), 256'(0));
        chk("refill_count", 256'(bus.refillCount_o), 256'(exp_cnt));
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[4];
        logic [255:0] blk_a;
        int s;

        vecs[0] = '{32'h0000_1234, 0, 0, 1'b0, 64'h1111_1111_1111_1111, 32'h0000_1220};
        vecs[1] = '{32'h0000_ABCD, 5, 0, 1'b0, 64'h0123_4567_89AB_CDEF, 32'h0000_ABC0};
        vecs[2] = '{32'h8000_001F, 0, 2, 1'b1, 64'h0F0F_0000_A5A5_0001, 32'h8000_0000};
        vecs[3] = '{32'hFFFF_FFE7, 2, 1, 1'b0, 64'h7654_3210_FEDC_BA98, 32'hFFFF_FFE0};

        bus.miss_i         = 1'b0;
        bus.missAddr_i     = '0;
        bus.memReqReady_i  = 1'b0;
        bus.memRespValid_i = 1'b0;
        bus.memRespData_i  = '0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 256'(bus.memReqValid_o), 256'(0));
        chk("rst_req_addr", 256'(bus.memReqAddr_o), 256'(0));
        chk("rst_wr_en", 256'(bus.wrEnable_o), 256'(0));
        chk("rst_wr_addr", 256'(bus.wrAddr_o), 256'(0));
        chk("rst_block", bus.instBlock_o, 256'(0));
        chk("rst_busy", 256'(bus.busy_o), 256'(0));
        chk("rst_count", 256'(bus.refillCount_o), 256'(0));
        reset = 1'b0;
        step();

        // Table-driven refills: latency, back-pressure, gaps + stray beat.
        for (int i = 0; i < 4; i++) begin
            run_refill(vecs[i]);
        end

        // Explicit block layout for the 0x11../0x44.. pattern.
        blk_a = make_block(64'h1111_1111_1111_1111);
        chk("layout_beat0", 256'(blk_a[63:0]), 256'(64'h1111_1111_1111_1111));
        chk("layout_beat3", 256'(blk_a[255:192]), 256'(64'h4444_4444_4444_4444));

        // Miss address changes mid-refill while miss stays high.
        sb.push_back('{32'h0000_0100, make_block(64'h0000_0000_0000_0AB1)});
        bus.miss_i     = 1'b1;
        bus.missAddr_i = 32'h0000_0100;
        step();
        bus.memReqReady_i = 1'b1;
        step();
        bus.memReqReady_i = 1'b0;
        bus.missAddr_i    = 32'h0000_2000;
        send_beats(64'h0000_0000_0000_0AB1, 0, s);
        chk("redirect_wr_en", 256'(bus.wrEnable_o), 256'(1));
        chk("redirect_wr_addr", 256'(bus.wrAddr_o), 256'(32'h0000_0100));
        step();
        exp_cnt++;
        chk("b2b_gap_valid", 256'(bus.memReqValid_o), 256'(0));
        sb.push_back('{32'h0000_2000, make_block(64'h0000_0000_0000_0CD2)});
        step();
        chk("b2b_req_valid", 256'(bus.memReqValid_o), 256'(1));
        chk("b2b_req_addr", 256'(bus.memReqAddr_o), 256'(32'h0000_2000));
        bus.miss_i        = 1'b0;
        bus.memReqReady_i = 1'b1;
        step();
        bus.memReqReady_i = 1'b0;
        send_beats(64'h0000_0000_0000_0CD2, 0, s);
        chk("b2b_wr_en", 256'(bus.wrEnable_o), 256'(1));
        step();
        exp_cnt++;
        chk("b2b_count", 256'(bus.refillCount_o), 256'(exp_cnt));
        step();

        // Reset in the middle of RESP after two beats.
        sb.push_back('{32'h0000_3000, make_block(64'h0000_0000_0000_0333)});
        bus.miss_i     = 1'b1;
        bus.missAddr_i = 32'h0000_3000;
        step();
        bus.miss_i        = 1'b0;
        bus.memReqReady_i = 1'b1;
        step();
        bus.memReqReady_i  = 1'b0;
        bus.memRespValid_i = 1'b1;
        bus.memRespData_i  = beat_val(64'h0000_0000_0000_0333, 0);
        step();
        bus.memRespData_i  = beat_val(64'h0000_0000_0000_0333, 1);
        step();
        bus.memRespData_i  = beat_val(64'h0000_0000_0000_0333, 2);
        reset = 1'b1;
        #1;
        void'(sb.pop_back());
        exp_cnt = 16'd0;
        chk("abort_req_valid", 256'(bus.memReqValid_o), 256'(0));
        chk("abort_req_addr", 256'(bus.memReqAddr_o), 256'(0));
        chk("abort_block", bus.instBlock_o, 256'(0));
        chk("abort_busy", 256'(bus.busy_o), 256'(0));
        chk("abort_count", 256'(bus.refillCount_o), 256'(0));
        step();
        reset = 1'b0;
        bus.memRespData_i = beat_val(64'h0000_0000_0000_0333, 3);
        step();
        bus.memRespValid_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("abort_no_fill", 256'(bus.wrEnable_o), 256'(0));
            chk("abort_idle", 256'(bus.busy_o), 256'(0));
            step();
        end
        run_refill('{32'h0000_4444, 1, 0, 1'b0, 64'h5555_0000_AAAA_0001, 32'h0000_4440});

        // Counter wrap from 0xFFFF to 0x0000.
        force dut.r_refill_cnt = 16'hFFFE;
        #1;
        release dut.r_refill_cnt;
        exp_cnt = 16'hFFFE;
        chk("preload_count", 256'(bus.refillCount_o), 256'(16'hFFFE));
        run_refill('{32'h0001_0010, 0, 0, 1'b0, 64'h0000_0000_0000_0007, 32'h0001_0000});
        run_refill('{32'h0002_003F, 0, 0, 1'b0, 64'h0000_0000_0000_0009, 32'h0002_0020});
        chk("wrap_zero", 256'(bus.refillCount_o), 256'(0));

        repeat (3) step();
        chk("sb_drained", 256'(sb.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
